// File: rtl/c2h_line_arbiter.sv
// Packet-granular round-robin mux of NUM_SRC line sources onto XDMA C2H stream 0, prefixing each packet with a tag header.
// Each packet costs one IDLE decision cycle plus one header beat. m_tready goes straight back to the granted source.
module c2h_line_arbiter #(
  parameter int          NUM_SRC    = 4,
  parameter int          DATA_WIDTH = 64,
  parameter logic [15:0] SYNC_WORD  = 16'hA55A,
  localparam int         GW         = $clog2(NUM_SRC),
  localparam int         KW         = DATA_WIDTH / 8
) (
  input  logic                    user_clk,
  input  logic                    user_rst,
  input  logic                    user_lnk_up,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata,
  input  logic [NUM_SRC*KW-1:0]   src_tkeep,
  input  logic [NUM_SRC-1:0]      src_tlast,
  input  logic [NUM_SRC-1:0]      src_tvalid,
  output logic [NUM_SRC-1:0]      src_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [KW-1:0]           m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [GW-1:0]           grant_id,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  typedef struct packed {
    logic [15:0] sync;
    logic [7:0]  src;
    logic [7:0]  rsvd;
    logic [31:0] seq;
  } hdr_t;

  state_t                state, state_nxt;
  logic [GW-1:0]         rr_ptr;
  logic [31:0]           seq [NUM_SRC];
  logic [DATA_WIDTH-1:0] s_dat [NUM_SRC];
  logic [KW-1:0]         s_keep [NUM_SRC];
  logic                  pick_vld;
  logic [GW-1:0]         pick;
  hdr_t                  hdr;
  logic                  hdr_fire;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign s_dat[i]  = src_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign s_keep[i] = src_tkeep[i*KW +: KW];
  end

  // Search starts one past the last grant so a re-requesting source goes to the back of the line.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!pick_vld && src_tvalid[GW'((int'(rr_ptr) + k) % NUM_SRC)]) begin
        pick_vld = 1'b1;
        pick     = GW'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
  end

  assign hdr      = '{sync: SYNC_WORD, src: 8'(grant_id), rsvd: 8'h00, seq: seq[grant_id]};
  assign hdr_fire = (state == HDR) && m_tready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    src_tready = '0;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    m_tdata    = '0;
    m_tkeep    = '0;
    case (state)
      IDLE: begin
        if (user_lnk_up && pick_vld) state_nxt = HDR;
      end
      HDR: begin
        m_tvalid = 1'b1;
        m_tkeep  = '1;
        m_tdata  = DATA_WIDTH'(hdr);
        if (m_tready) state_nxt = DATA;
      end
      DATA: begin
        m_tdata              = s_dat[grant_id];
        m_tkeep              = s_keep[grant_id];
        m_tlast              = src_tlast[grant_id];
        m_tvalid             = src_tvalid[grant_id];
        src_tready[grant_id] = m_tready;
        if (src_tvalid[grant_id] && m_tready && src_tlast[grant_id]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state    <= IDLE;
      rr_ptr   <= GW'(NUM_SRC - 1);
      grant_id <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && user_lnk_up && pick_vld) begin
        grant_id <= pick;
        rr_ptr   <= pick;
      end
    end
  end

  // Sequence number counts headers actually accepted, wrapping at 2^32.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      for (int i = 0; i < NUM_SRC; i++) seq[i] <= '0;
    end else if (hdr_fire) begin
      seq[grant_id] <= seq[grant_id] + 32'd1;
    end
  end

endmodule

// File: tb/tb_c2h_line_arbiter.sv
// Directed bench for c2h_line_arbiter: reset, single source, full round robin, random backpressure, link gating, mid-packet reset.
module tb_c2h_line_arbiter;
  localparam int NS = 4;
  localparam int DW = 64;
  localparam int KW = DW / 8;

  typedef logic [72:0] beat_t;

  logic             user_clk = 1'b0;
  logic             user_rst;
  logic             user_lnk_up;
  logic [NS*DW-1:0] src_tdata;
  logic [NS*KW-1:0] src_tkeep;
  logic [NS-1:0]    src_tlast;
  logic [NS-1:0]    src_tvalid;
  logic [NS-1:0]    src_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tlast;
  logic             m_tvalid;
  logic             m_tready;
  logic [1:0]       grant_id;
  logic             busy;

  always #5 user_clk = ~user_clk;

  c2h_line_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .SYNC_WORD(16'hA55A)) dut (
    .user_clk(user_clk), .user_rst(user_rst), .user_lnk_up(user_lnk_up),
    .src_tdata(src_tdata), .src_tkeep(src_tkeep), .src_tlast(src_tlast),
    .src_tvalid(src_tvalid), .src_tready(src_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .grant_id(grant_id), .busy(busy)
  );

  int       checks = 0;
  int       errors = 0;
  int       pkts_left [NS];
  int       plen [NS];
  int       bidx [NS];
  int       pidx [NS];
  logic [NS-1:0] fire;
  logic     prev_stall;
  beat_t    prev_beat;
  int       busy_cnt;
  beat_t    out_q [$];
  beat_t    exp_q [$];

  function automatic logic [63:0] beat_dat(int s, int p, int j);
    return {16'hDA7A, 8'(s), 8'(p), 32'(j)};
  endfunction

  function automatic beat_t hdr_beat(int s, int unsigned sq);
    return {1'b0, 8'hFF, 16'hA55A, 8'(s), 8'h00, 32'(sq)};
  endfunction

  function automatic void exp_pkt(int s, int unsigned sq, int p, int len);
    exp_q.push_back(hdr_beat(s, sq));
    for (int j = 0; j < len; j++)
      exp_q.push_back({(j == len - 1), ((j == len - 1) ? 8'h0F : 8'hFF), beat_dat(s, p, j)});
  endfunction

  function automatic bit all_done();
    for (int i = 0; i < NS; i++) if (pkts_left[i] != 0) return 1'b0;
    return !busy;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int s, input int n, input int len);
    pkts_left[s] = n;
    plen[s]      = len;
    bidx[s]      = 0;
    pidx[s]      = 0;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NS; i++) load(i, 0, 1);
    prev_stall = 1'b0;
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < NS; i++) begin
      logic lb;
      lb = (bidx[i] == plen[i] - 1);
      src_tvalid[i]          = (pkts_left[i] > 0);
      src_tlast[i]           = lb;
      src_tkeep[i*KW +: KW]  = lb ? 8'h0F : 8'hFF;
      src_tdata[i*DW +: DW]  = beat_dat(i, pidx[i], bidx[i]);
    end
  endtask

  // One clock: drive at edge+2, sample at edge+3, advance source models after the next edge.
  task automatic cycle(input bit rnd);
    beat_t cur;
    drive_srcs();
    m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    cur = {m_tlast, m_tkeep, m_tdata};
    if (prev_stall) chk("hold", 128'(cur), 128'(prev_beat));
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = cur;
    if (m_tvalid && m_tready) out_q.push_back(cur);
    busy_cnt += int'(busy);
    fire = src_tvalid & src_tready;
    @(posedge user_clk);
    #2;
    for (int i = 0; i < NS; i++) begin
      if (fire[i]) begin
        bidx[i]++;
        if (bidx[i] == plen[i]) begin
          bidx[i] = 0;
          pidx[i]++;
          pkts_left[i]--;
        end
      end
    end
  endtask

  task automatic run_done(input bit rnd, input int budget, input string tag);
    for (int c = 0; c < budget && !all_done(); c++) cycle(rnd);
    chk({tag, "_done"}, 128'(all_done()), 128'(1));
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_n"}, 128'(out_q.size()), 128'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
      chk($sformatf("%s_%0d", tag, k), 128'(out_q[k]), 128'(exp_q[k]));
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"},  128'(src_tready), 128'(0));
    chk({tag, "_vld"},  128'(m_tvalid),   128'(0));
    chk({tag, "_last"}, 128'(m_tlast),    128'(0));
    chk({tag, "_dat"},  128'(m_tdata),    128'(0));
    chk({tag, "_keep"}, 128'(m_tkeep),    128'(0));
    chk({tag, "_busy"}, 128'(busy),       128'(0));
    chk({tag, "_gnt"},  128'(grant_id),   128'(0));
  endtask

  task automatic do_reset();
    user_rst = 1'b1;
    clear_srcs();
    drive_srcs();
    @(posedge user_clk);
    #2;
    user_rst = 1'b0;
  endtask

  initial begin
    user_rst    = 1'b1;
    user_lnk_up = 1'b1;
    m_tready    = 1'b0;
    busy_cnt    = 0;
    clear_srcs();
    drive_srcs();
    #3;
    chk_zero("rst");
    @(posedge user_clk);
    @(posedge user_clk);
    #2;
    user_rst = 1'b0;

    // Single source, two 3-beat packets: second header carries seq 1.
    load(0, 2, 3);
    busy_cnt = 0;
    repeat (6) cycle(1'b0);
    chk("t1_busy", 128'(busy_cnt), 128'(4));
    run_done(1'b0, 30, "t1");
    exp_pkt(0, 0, 0, 3);
    exp_pkt(0, 1, 1, 3);
    cmp_stream("t1");

    // All sources busy from reset: order 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < NS; i++) load(i, 2, 2);
    run_done(1'b0, 80, "t2");
    for (int i = 0; i < NS; i++) exp_pkt(i, 0, 0, 2);
    for (int i = 0; i < NS; i++) exp_pkt(i, 1, 1, 2);
    chk("t2_gnt", 128'(grant_id), 128'(3));
    cmp_stream("t2");

    // Random backpressure, 16-beat packets from sources 1 and 3.
    load(1, 2, 16);
    load(3, 2, 16);
    run_done(1'b1, 800, "t3");
    exp_pkt(1, 2, 0, 16);
    exp_pkt(3, 2, 0, 16);
    exp_pkt(1, 3, 1, 16);
    exp_pkt(3, 3, 1, 16);
    cmp_stream("t3");
    prev_stall = 1'b0;

    // Link down blocks grants; link drop mid-DATA does not abort.
    user_lnk_up = 1'b0;
    load(2, 1, 2);
    repeat (5) begin
      cycle(1'b0);
      chk("t4_vld", 128'(m_tvalid), 128'(0));
      chk("t4_rdy", 128'(src_tready), 128'(0));
    end
    user_lnk_up = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    user_lnk_up = 1'b0;
    chk("t4_busy", 128'(busy), 128'(1));
    chk("t4_gnt", 128'(grant_id), 128'(2));
    run_done(1'b0, 20, "t4");
    exp_pkt(2, 2, 0, 2);
    cmp_stream("t4");
    user_lnk_up = 1'b1;

    // Async reset during the third data beat of a source-3 packet.
    load(3, 1, 4);
    repeat (4) cycle(1'b0);
    drive_srcs();
    m_tready = 1'b1;
    #1;
    chk("t5_pre_dat", 128'(m_tdata), 128'(beat_dat(3, 0, 2)));
    chk("t5_pre_vld", 128'(m_tvalid), 128'(1));
    user_rst = 1'b1;
    #1;
    chk_zero("t5_rst");
    exp_q.push_back(hdr_beat(3, 4));
    exp_q.push_back({1'b0, 8'hFF, beat_dat(3, 0, 0)});
    exp_q.push_back({1'b0, 8'hFF, beat_dat(3, 0, 1)});
    cmp_stream("t5a");
    do_reset();
    load(1, 1, 1);
    load(2, 1, 1);
    load(3, 1, 1);
    run_done(1'b0, 30, "t5");
    exp_pkt(1, 0, 0, 1);
    exp_pkt(2, 0, 0, 1);
    exp_pkt(3, 0, 0, 1);
    cmp_stream("t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
